// File: rtl/verify_round_seq.sv
// -----------------------------------------------------------------------------
// verify_round_seq
//
// Sequencer for the verification side of an MPC-in-the-head signature. It
// walks a fixed chain of stage engines (challenge, seed expansion, commitment
// trees, final hash). Between SEED and CHT it runs one round engine per MPC
// round. The challenge hash is computed with the opened/unopened split taken
// from lc_i. At the end the computed hash h_i is compared against ht_i.
//
// Parameters
//   N_ROUNDS  total MPC rounds (2..31)
//   TAU       opened rounds (1..N_ROUNDS-1)
//   DW        digest width
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   start           run request (level); a new run needs start low after done
//   ht_i            expected challenge hash
//   lc_i            TAU x 5-bit opened-round indices, slot 0 in the MSBs
//   cv_i            TAU x DW opened-round Cv digests, slot 0 in the MSBs
//   stg_req/done    7 stage handshakes, bit0..6 = CHAL,SEED,CHT,CVT,CSN,CSTAR,HCP
//   h_i             final hash delivered by the HCP stage
//   rnd_req/done    per-round engine handshake
//   rnd_idx         current round j
//   rnd_open        round j is one of the opened rounds
//   rnd_slot        running count of opened (or unopened) rounds seen so far
//   rnd_ch/cn/cv    round engine results
//   ch/cn/cv_buf    per-round result buffers, round 0 in the MSBs
//   done, ok, err   run finished / hash matched / malformed lc_i
//
// Build option
//   VERIFY_LC_CHECK_EN  when defined, CHK rejects an lc_i that holds an index
//                       >= N_ROUNDS or a repeated index. When undefined, err
//                       is tied low and CHAL advances directly to SEED.
// -----------------------------------------------------------------------------
module verify_round_seq #(
  parameter int N_ROUNDS = 8,
  parameter int TAU      = 4,
  parameter int DW       = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DW-1:0]          ht_i,
  input  logic [TAU*5-1:0]       lc_i,
  input  logic [TAU*DW-1:0]      cv_i,
  output logic [6:0]             stg_req,
  input  logic [6:0]             stg_done,
  input  logic [DW-1:0]          h_i,
  output logic                   rnd_req,
  output logic [4:0]             rnd_idx,
  output logic                   rnd_open,
  output logic [2:0]             rnd_slot,
  input  logic                   rnd_done,
  input  logic [DW-1:0]          rnd_ch,
  input  logic [DW-1:0]          rnd_cn,
  input  logic [DW-1:0]          rnd_cv,
  output logic [N_ROUNDS*DW-1:0] ch_buf,
  output logic [N_ROUNDS*DW-1:0] cn_buf,
  output logic [N_ROUNDS*DW-1:0] cv_buf,
  output logic                   done,
  output logic                   ok,
  output logic                   err
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_CHAL  = 4'd1;
  localparam logic [3:0] ST_CHK   = 4'd2;
  localparam logic [3:0] ST_SEED  = 4'd3;
  localparam logic [3:0] ST_RND   = 4'd4;
  localparam logic [3:0] ST_NEXT  = 4'd5;
  localparam logic [3:0] ST_CHT   = 4'd6;
  localparam logic [3:0] ST_CVT   = 4'd7;
  localparam logic [3:0] ST_CSN   = 4'd8;
  localparam logic [3:0] ST_CSTAR = 4'd9;
  localparam logic [3:0] ST_HCP   = 4'd10;
  localparam logic [3:0] ST_CMP   = 4'd11;

  localparam logic [2:0] B_CHAL  = 3'd0;
  localparam logic [2:0] B_SEED  = 3'd1;
  localparam logic [2:0] B_CHT   = 3'd2;
  localparam logic [2:0] B_CVT   = 3'd3;
  localparam logic [2:0] B_CSN   = 3'd4;
  localparam logic [2:0] B_CSTAR = 3'd5;
  localparam logic [2:0] B_HCP   = 3'd6;

  localparam logic [4:0] J_END = 5'(N_ROUNDS);

  logic [3:0]    state;
  logic [4:0]    j;
  logic [4:0]    open_cnt;
  logic [4:0]    unopen_cnt;
  logic          in_stage;
  logic [2:0]    stg_idx;
  logic [3:0]    stg_next;
  logic          j_end;
  logic          rnd_match;
  logic          rnd_fire;
  logic [DW-1:0] cv_sel;

  assign rnd_idx  = j;
  assign j_end    = (j == J_END);
  assign rnd_fire = (state == ST_RND) && !j_end && rnd_done;

  // All seven engine stages share one handshake, so decode which request bit
  // the current state owns and which state follows it.
  always_comb begin
    in_stage = 1'b1;
    stg_idx  = B_CHAL;
    stg_next = ST_IDLE;
    case (state)
      ST_CHAL: begin
        stg_idx = B_CHAL;
`ifdef VERIFY_LC_CHECK_EN
        stg_next = ST_CHK;
`else
        // With no index check there is nothing for CHK to do, so skip it.
        stg_next = ST_SEED;
`endif
      end
      ST_SEED:  begin stg_idx = B_SEED;  stg_next = ST_RND;   end
      ST_CHT:   begin stg_idx = B_CHT;   stg_next = ST_CVT;   end
      ST_CVT:   begin stg_idx = B_CVT;   stg_next = ST_CSN;   end
      ST_CSN:   begin stg_idx = B_CSN;   stg_next = ST_CSTAR; end
      ST_CSTAR: begin stg_idx = B_CSTAR; stg_next = ST_HCP;   end
      ST_HCP:   begin stg_idx = B_HCP;   stg_next = ST_CMP;   end
      default:  in_stage = 1'b0;
    endcase
  end

  // Round j is opened when it appears in any lc_i slot. The flag is only
  // meaningful while a real round is in progress, so it is gated to that.
  always_comb begin
    rnd_match = 1'b0;
    for (int k = 0; k < TAU; k++) begin
      if (lc_i[(TAU-1-k)*5 +: 5] == j) rnd_match = 1'b1;
    end
  end

  assign rnd_open = (state == ST_RND) && !j_end && rnd_match;
  assign rnd_slot = rnd_open ? open_cnt[2:0] : unopen_cnt[2:0];

  // Opened rounds take their Cv digest from the signature, in slot order;
  // unopened rounds take the one recomputed by the round engine.
  always_comb begin
    cv_sel = rnd_cv;
    if (rnd_open) begin
      for (int k = 0; k < TAU; k++) begin
        if (open_cnt == 5'(k)) cv_sel = cv_i[(TAU-1-k)*DW +: DW];
      end
    end
  end

`ifdef VERIFY_LC_CHECK_EN
  logic lc_bad;

  // Any out-of-range index or any repeated index makes lc_i unusable.
  always_comb begin
    lc_bad = 1'b0;
    for (int a = 0; a < TAU; a++) begin
      if (lc_i[(TAU-1-a)*5 +: 5] >= J_END) lc_bad = 1'b1;
      for (int b = a + 1; b < TAU; b++) begin
        if (lc_i[(TAU-1-a)*5 +: 5] == lc_i[(TAU-1-b)*5 +: 5]) lc_bad = 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  // Capture each round's results into its slot of the buffers when the
  // round engine completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_buf <= '0;
      cn_buf <= '0;
      cv_buf <= '0;
    end else if (rnd_fire) begin
      for (int r = 0; r < N_ROUNDS; r++) begin
        if (j == 5'(r)) begin
          ch_buf[(N_ROUNDS-1-r)*DW +: DW] <= rnd_ch;
          cn_buf[(N_ROUNDS-1-r)*DW +: DW] <= rnd_cn;
          cv_buf[(N_ROUNDS-1-r)*DW +: DW] <= cv_sel;
        end
      end
    end
  end

  // Main sequencer. Stage states raise their request one cycle after entry,
  // hold it until the engine answers, then drop it and move on, so at most
  // one request is ever high. done/ok/err remain set until start is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      j          <= '0;
      open_cnt   <= '0;
      unopen_cnt <= '0;
      stg_req    <= '0;
      rnd_req    <= 1'b0;
      done       <= 1'b0;
      ok         <= 1'b0;
`ifdef VERIFY_LC_CHECK_EN
      err        <= 1'b0;
`endif
    end else if (in_stage) begin
      if (stg_done[stg_idx]) begin
        stg_req[stg_idx] <= 1'b0;
        state            <= stg_next;
      end else begin
        stg_req[stg_idx] <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!start) begin
            done <= 1'b0;
            ok   <= 1'b0;
`ifdef VERIFY_LC_CHECK_EN
            err  <= 1'b0;
`endif
          end else if (!done) begin
            state <= ST_CHAL;
          end
        end
        ST_CHK: begin
`ifdef VERIFY_LC_CHECK_EN
          if (lc_bad) begin
            done  <= 1'b1;
            ok    <= 1'b0;
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_SEED;
          end
`else
          state <= ST_SEED;
`endif
        end
        ST_RND: begin
          if (j_end) begin
            j          <= '0;
            open_cnt   <= '0;
            unopen_cnt <= '0;
            state      <= ST_CHT;
          end else if (rnd_done) begin
            rnd_req <= 1'b0;
            if (rnd_open) open_cnt   <= open_cnt + 5'd1;
            else          unopen_cnt <= unopen_cnt + 5'd1;
            state   <= ST_NEXT;
          end else begin
            rnd_req <= 1'b1;
          end
        end
        ST_NEXT: begin
          j     <= j + 5'd1;
          state <= ST_RND;
        end
        ST_CMP: begin
          ok    <= (h_i == ht_i);
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verify_round_seq.sv
// -----------------------------------------------------------------------------
// tb_verify_round_seq
//
// Self-checking bench for verify_round_seq. Engine models answer stage and
// round requests after three cycles, or in the same cycle in zero-latency
// mode. Each run pushes the expected round handshakes and the final outcome
// onto queues, and these are popped as the DUT produces them. A second
// instance built with 16 rounds / 8 opened checks the larger configuration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_verify_round_seq;

  localparam int N   = 8;
  localparam int T   = 4;
  localparam int W   = 256;
  localparam int N16 = 16;
  localparam int T16 = 8;
  localparam int W16 = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   ht_i = '0;
  logic [W-1:0]   h_i = '0;
  logic [T*5-1:0] lc_i = '0;
  logic [T*W-1:0] cv_i = '0;
  logic [6:0]     stg_req;
  logic [6:0]     stg_done;
  logic [6:0]     stg_done_slow = '0;
  logic           rnd_req, rnd_open, rnd_done;
  logic           rnd_done_slow = 1'b0;
  logic [4:0]     rnd_idx;
  logic [2:0]     rnd_slot;
  logic [W-1:0]   rnd_ch = '0;
  logic [W-1:0]   rnd_cn = '0;
  logic [W-1:0]   rnd_cv = '0;
  logic [N*W-1:0] ch_buf, cn_buf, cv_buf;
  logic           done, ok, err;
  bit             zl = 1'b0;

  logic               start16 = 1'b0;
  logic [W16-1:0]     ht16 = '0;
  logic [W16-1:0]     h16 = '0;
  logic [T16*5-1:0]   lc16 = '0;
  logic [T16*W16-1:0] cv16 = '0;
  logic [W16-1:0]     rdat16 = '0;
  logic [6:0]         stg_req16, stg_done16;
  logic               rnd_req16, rnd_open16, rnd_done16;
  logic [4:0]         rnd_idx16;
  logic [2:0]         rnd_slot16;
  logic [N16*W16-1:0] ch16, cn16, cv16b;
  logic               done16, ok16, err16;

  int checks = 0;
  int failures = 0;

  logic [8:0]   round_q[$];
  logic [2:0]   result_q[$];
  logic [W-1:0] exp_ch[N];
  logic [W-1:0] exp_cn[N];
  logic [W-1:0] exp_cv[N];
  bit           exp_bad = 1'b0;
  logic [15:0]  seed = '0;

  int         cyc = 0;
  int         chal_first = -1;
  int         seed_first = -1;
  int         chal_hi = 0;
  int         viol = 0;
  int         hs16 = 0;
  int         open16 = 0;
  logic [6:0] first_req = '0;
  int         scnt[7];
  int         rcnt = 0;

  assign stg_done   = zl ? stg_req : stg_done_slow;
  assign rnd_done   = zl ? rnd_req : rnd_done_slow;
  assign stg_done16 = stg_req16;
  assign rnd_done16 = rnd_req16;

  verify_round_seq dut (
    .clk(clk), .reset(reset), .start(start), .ht_i(ht_i), .lc_i(lc_i),
    .cv_i(cv_i), .stg_req(stg_req), .stg_done(stg_done), .h_i(h_i),
    .rnd_req(rnd_req), .rnd_idx(rnd_idx), .rnd_open(rnd_open),
    .rnd_slot(rnd_slot), .rnd_done(rnd_done), .rnd_ch(rnd_ch),
    .rnd_cn(rnd_cn), .rnd_cv(rnd_cv), .ch_buf(ch_buf), .cn_buf(cn_buf),
    .cv_buf(cv_buf), .done(done), .ok(ok), .err(err)
  );

  verify_round_seq #(.N_ROUNDS(N16), .TAU(T16), .DW(W16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .ht_i(ht16), .lc_i(lc16),
    .cv_i(cv16), .stg_req(stg_req16), .stg_done(stg_done16), .h_i(h16),
    .rnd_req(rnd_req16), .rnd_idx(rnd_idx16), .rnd_open(rnd_open16),
    .rnd_slot(rnd_slot16), .rnd_done(rnd_done16), .rnd_ch(rdat16),
    .rnd_cn(rdat16), .rnd_cv(rdat16), .ch_buf(ch16), .cn_buf(cn16),
    .cv_buf(cv16b), .done(done16), .ok(ok16), .err(err16)
  );

  always #5 clk = ~clk;

  // Digest pattern tagged with its source, round and run seed.
  function automatic logic [W-1:0] mk(input logic [7:0] tag, input logic [4:0] jj,
                                      input logic [15:0] s);
    return {8{tag, 3'b000, jj, s}};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Engine models: each request is answered after three cycles high, and the
  // round engine presents results derived from the current round index.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 7; k++) begin
      if (stg_req[k]) begin
        scnt[k]++;
        stg_done_slow[k] = (scnt[k] == 3);
      end else begin
        scnt[k] = 0;
        stg_done_slow[k] = 1'b0;
      end
    end
    if (rnd_req) begin
      rcnt++;
      rnd_done_slow = (rcnt == 3);
    end else begin
      rcnt = 0;
      rnd_done_slow = 1'b0;
    end
    rnd_ch = mk(8'hC1, rnd_idx, seed);
    rnd_cn = mk(8'hC2, rnd_idx, seed);
    rnd_cv = mk(8'hC3, rnd_idx, seed);
  end

  // Monitor: request timing, one-hot requests, and scoreboard pops on each
  // round handshake of either instance.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (stg_req[0]) begin
      chal_hi++;
      if (chal_first < 0) chal_first = cyc;
    end
    if (stg_req[1] && seed_first < 0) seed_first = cyc;
    if (first_req == 7'd0 && stg_req != 7'd0) first_req = stg_req;
    if ($countones({stg_req, rnd_req}) > 1 || $countones({stg_req16, rnd_req16}) > 1)
      viol++;
    if (rnd_req && rnd_done) begin
      if (round_q.size() == 0) begin
        checkOutput("rnd_extra", round_q.size(), 1);
      end else begin
        e = round_q.pop_front();
        checkOutput($sformatf("rnd_j%0d", e[8:4]), {rnd_idx, rnd_open, rnd_slot}, e);
      end
    end
    if (rnd_req16 && rnd_done16) begin
      hs16++;
      if (rnd_open16) begin
        checkOutput("slot16", rnd_slot16, open16);
        open16++;
      end
    end
  end

  // Set up one run: drive lc_i/cv_i/hashes, derive the expected handshakes,
  // buffers and outcome, then raise start.
  task automatic applyStimulus(input int l0, input int l1, input int l2, input int l3,
                               input bit hmatch, input bit zero_lat,
                               input logic [15:0] s);
    int lc[4];
    int oc, uc;
    bit open, bad;
    logic [W-1:0] slotv[T];
    lc = '{l0, l1, l2, l3};
    seed = s;
    zl = zero_lat;
    for (int k = 0; k < T; k++) begin
      lc_i[(T-1-k)*5 +: 5] = 5'(lc[k]);
      slotv[k] = mk(8'hA0 + 8'(k), 5'd31, s);
      cv_i[(T-1-k)*W +: W] = slotv[k];
    end
    ht_i = {8{$urandom}};
    h_i  = hmatch ? ht_i : (ht_i ^ 256'd1);
    bad = 1'b0;
`ifdef VERIFY_LC_CHECK_EN
    for (int a = 0; a < T; a++) begin
      if (lc[a] >= N) bad = 1'b1;
      for (int b = a + 1; b < T; b++) if (lc[a] == lc[b]) bad = 1'b1;
    end
`endif
    exp_bad = bad;
    oc = 0;
    uc = 0;
    if (!bad) begin
      for (int jj = 0; jj < N; jj++) begin
        open = (lc[0] == jj) || (lc[1] == jj) || (lc[2] == jj) || (lc[3] == jj);
        round_q.push_back({5'(jj), open, 3'(open ? oc : uc)});
        exp_ch[jj] = mk(8'hC1, 5'(jj), s);
        exp_cn[jj] = mk(8'hC2, 5'(jj), s);
        exp_cv[jj] = open ? slotv[oc] : mk(8'hC3, 5'(jj), s);
        if (open) oc++;
        else uc++;
      end
    end
    result_q.push_back(bad ? 3'b101 : {1'b1, hmatch, 1'b0});
    chal_first = -1;
    seed_first = -1;
    chal_hi    = 0;
    first_req  = '0;
    start      = 1'b1;
  endtask

  // Wait for done and compare outcome, buffers, hold and clear behaviour.
  task automatic checkRun();
    logic [2:0] er;
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    checkOutput("done_seen", done, 1);
    er = result_q.pop_front();
    checkOutput("result", {done, ok, err}, er);
    checkOutput("first_req", first_req, 7'b0000001);
    checkOutput("rnd_left", round_q.size(), 0);
    checkOutput("seed_req", seed_first >= 0, !exp_bad);
    if (!exp_bad) begin
      for (int jj = 0; jj < N; jj++) begin
        checkOutput($sformatf("ch_buf%0d", jj), ch_buf[(N-1-jj)*W +: W], exp_ch[jj]);
        checkOutput($sformatf("cn_buf%0d", jj), cn_buf[(N-1-jj)*W +: W], exp_cn[jj]);
        checkOutput($sformatf("cv_buf%0d", jj), cv_buf[(N-1-jj)*W +: W], exp_cv[jj]);
      end
    end
    if (start) begin
      repeat (3) @(negedge clk);
      checkOutput("done_hold", done, 1);
      checkOutput("no_restart", {stg_req, rnd_req}, 0);
      start = 1'b0;
    end
    @(negedge clk);
    checkOutput("done_clear", {done, ok, err}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < T16; k++) lc16[(T16-1-k)*5 +: 5] = 5'(2*k + 1);
    repeat (2) @(negedge clk);
    checkOutput("rst_req0", {stg_req, rnd_req}, 0);
    checkOutput("rst_flags0", {done, ok, err}, 0);
    checkOutput("rst_j0", rnd_idx, 0);
    checkOutput("rst_bufs0", {ch_buf != 0, cn_buf != 0, cv_buf != 0}, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] run: lc={1,3,4,6} hash match");
    applyStimulus(1, 3, 4, 6, 1'b1, 1'b0, 16'h1111);
    checkRun();

    $display("[TB] run: lc={1,3,4,6} hash mismatch");
    applyStimulus(1, 3, 4, 6, 1'b0, 1'b0, 16'h2222);
    checkRun();

    $display("[TB] run: zero-latency engines");
    applyStimulus(1, 3, 4, 6, 1'b1, 1'b1, 16'h3333);
    checkRun();
    checkOutput("chal_1cyc", chal_hi, 1);
`ifdef VERIFY_LC_CHECK_EN
    checkOutput("seed_gap", seed_first - chal_first, 3);
`else
    checkOutput("seed_gap", seed_first - chal_first, 2);
`endif

    $display("[TB] run: lc={2,2,5,7}");
    applyStimulus(2, 2, 5, 7, 1'b1, 1'b0, 16'h4444);
    checkRun();

    $display("[TB] run: lc={0,1,2,9}");
    applyStimulus(0, 1, 2, 9, 1'b1, 1'b0, 16'h5555);
    checkRun();

    $display("[TB] run: start dropped mid-run");
    applyStimulus(0, 2, 5, 7, 1'b1, 1'b0, 16'h6666);
    repeat (4) @(negedge clk);
    start = 1'b0;
    checkRun();

    $display("[TB] run: reset during round 5");
    applyStimulus(1, 3, 4, 6, 1'b1, 1'b0, 16'h7777);
    for (int i = 0; i < 2000 && !(rnd_req && rnd_idx == 5'd5); i++) @(negedge clk);
    checkOutput("reach_j5", rnd_idx, 5);
    reset = 1'b0;
    #1;
    checkOutput("rst_req", {stg_req, rnd_req}, 0);
    checkOutput("rst_flags", {done, ok, err}, 0);
    checkOutput("rst_j", rnd_idx, 0);
    checkOutput("rst_bufs", {ch_buf != 0, cn_buf != 0, cv_buf != 0}, 0);
    round_q.delete();
    result_q.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1, 3, 4, 6, 1'b1, 1'b0, 16'h8888);
    checkRun();

    $display("[TB] run: 16-round build");
    start16 = 1'b1;
    for (int i = 0; i < 3000 && !done16; i++) @(negedge clk);
    checkOutput("done16", done16, 1);
    checkOutput("ok16", {ok16, err16}, 2'b10);
    checkOutput("hs16", hs16, 16);
    checkOutput("open16", open16, 8);
    start16 = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("onehot", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
